// File: rtl/ram_task2_if.sv
// ram_task2_if: access bus between the L1 cache (master) and its backing RAM (slave).
//   we        master->slave  write enable, write takes effect at next rising edge
//   address   master->slave  word address for both read and write
//   wdata     master->slave  write data
//   rdata     slave->master  combinational read data
//   init_busy slave->master  high during reset and the post-reset clear sweep
interface ram_task2_if #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ADDR_W = 10
);
    logic              we;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              init_busy;

    modport master (
        output we,
        output address,
        output wdata,
        input  rdata,
        input  init_busy
    );

    modport slave (
        input  we,
        input  address,
        input  wdata,
        output rdata,
        output init_busy
    );
endinterface

// File: rtl/ram_task2.sv
// ram_task2: single-port DEPTH x DATA_W data RAM behind the L1 cache.
//   clk  rising-edge clock
//   rst  synchronous active-high reset; restarts the clear sweep
//   bus  slave side of ram_task2_if (we/address/wdata in, rdata/init_busy out)
// Reads are combinational from address; writes land on the rising edge. After every reset
// the whole array is swept to INIT_VALUE, one word per cycle, while init_busy is high.
module ram_task2 #(
    parameter int unsigned          DATA_W     = 10,
    parameter int unsigned          ADDR_W     = 10,
    parameter int unsigned          DEPTH      = 1024,
    parameter logic [DATA_W-1:0]    INIT_VALUE = '0
) (
    input logic         clk,
    input logic         rst,
    ram_task2_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {StInit, StReady} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              in_range;
    logic              busy;

    // Out-of-range addresses exist only when the array does not fill the address space.
    if (DEPTH < (32'd1 << ADDR_W)) begin : g_partial
        assign in_range = (bus.address < ADDR_W'(DEPTH));
    end else begin : g_full
        assign in_range = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_addr  = bus.address;
        mem_wdata = bus.wdata;
        unique case (state_q)
            StInit: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = INIT_VALUE;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LastIdx) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                // An X on we fails the if and is treated as no write.
                if (bus.we && in_range) begin
                    mem_we = 1'b1;
                end
            end
            default: begin
                state_d = StInit;
            end
        endcase
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    assign busy          = rst || (state_q != StReady);
    assign bus.init_busy = busy;

    always_comb begin
        bus.rdata = '0;
        if (!busy && in_range) begin
            bus.rdata = mem_q[bus.address];
        end
    end

endmodule

// File: tb/tb_ram_task2.sv
// tb_ram_task2: directed bench for ram_task2. A full-depth instance and a DEPTH=1000 instance
// share clock and reset; expected values are queued when stimulus is applied and compared
// when the combinational output is sampled.
module tb_ram_task2;

    logic clk;
    logic rst;

    ram_task2_if #(.DATA_W(10), .ADDR_W(10)) bus1 ();
    ram_task2_if #(.DATA_W(10), .ADDR_W(10)) bus2 ();

    ram_task2 #(.DATA_W(10), .ADDR_W(10), .DEPTH(1024), .INIT_VALUE(10'd0)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    ram_task2 #(.DATA_W(10), .ADDR_W(10), .DEPTH(1000), .INIT_VALUE(10'd0)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned vectors;
    int unsigned miscompares;
    logic [31:0] exp_q [$];

    task automatic push_exp(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: observed %h but scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    // Read on one instance: drive address after the falling edge, compare 1ns later.
    task automatic rd(input int which, input logic [9:0] a, input logic [9:0] e,
                      input string tag);
        @(negedge clk);
        if (which == 1) bus1.address = a;
        else            bus2.address = a;
        push_exp({22'd0, e});
        #1;
        chk(tag, (which == 1) ? {22'd0, bus1.rdata} : {22'd0, bus2.rdata});
    endtask

    task automatic wr(input int which, input logic [9:0] a, input logic [9:0] d);
        @(negedge clk);
        if (which == 1) begin
            bus1.we = 1'b1; bus1.address = a; bus1.wdata = d;
        end else begin
            bus2.we = 1'b1; bus2.address = a; bus2.wdata = d;
        end
        @(negedge clk);
        bus1.we = 1'b0;
        bus2.we = 1'b0;
    endtask

    // Hold reset for rst_cycles edges, release it, and count cycles until each instance is ready.
    task automatic do_reset(input int rst_cycles, input string tag);
        int n;
        int n2;
        @(negedge clk);
        rst = 1'b1;
        repeat (rst_cycles) @(negedge clk);
        push_exp(32'd1);
        chk({tag, "_busy_in_rst"}, {31'd0, bus1.init_busy});
        push_exp(32'd0);
        chk({tag, "_rdata_in_rst"}, {22'd0, bus1.rdata});
        rst = 1'b0;
        #1;
        push_exp(32'd1);
        chk({tag, "_busy_after_rel"}, {31'd0, bus1.init_busy});
        push_exp(32'd0);
        chk({tag, "_rdata_in_init"}, {22'd0, bus1.rdata});
        n  = 0;
        n2 = 0;
        while (bus1.init_busy && n < 2000) begin
            @(negedge clk);
            n++;
            if (!bus2.init_busy && n2 == 0) n2 = n;
        end
        push_exp(32'd1024);
        chk({tag, "_sweep_len_1024"}, n);
        push_exp(32'd1000);
        chk({tag, "_sweep_len_1000"}, n2);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        bus1.we = 1'b0; bus1.address = '0; bus1.wdata = '0;
        bus2.we = 1'b0; bus2.address = '0; bus2.wdata = '0;

        // Writes attempted during the sweep must be ignored.
        bus1.we = 1'b1; bus1.address = 10'd5; bus1.wdata = 10'h123;
        do_reset(2, "rst1");
        bus1.we = 1'b0;
        rd(1, 10'd0,   10'd0, "sweep_a0");
        rd(1, 10'd511, 10'd0, "sweep_a511");
        rd(1, 10'd1023, 10'd0, "sweep_a1023");
        rd(1, 10'd5,   10'd0, "init_write_ignored");

        // Basic write / read.
        wr(1, 10'h0A4, 10'h155);
        wr(1, 10'h0A5, 10'h2AA);
        rd(1, 10'h0A4, 10'h155, "rw_a0a4");
        rd(1, 10'h0A5, 10'h2AA, "rw_a0a5");
        rd(1, 10'h0A4, 10'h155, "rw_a0a4_again");

        // Same-cycle collision: old data before the edge, new data after it.
        wr(1, 10'h010, 10'h001);
        @(negedge clk);
        bus1.we = 1'b1; bus1.address = 10'h010; bus1.wdata = 10'h3FF;
        #1;
        push_exp(32'h001);
        chk("collide_before_edge", {22'd0, bus1.rdata});
        @(posedge clk);
        #1;
        push_exp(32'h3FF);
        chk("collide_after_edge", {22'd0, bus1.rdata});
        @(negedge clk);
        bus1.we = 1'b0;

        // Back-to-back writes, then readback.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus1.we = 1'b1; bus1.address = 10'(10'h300 + i); bus1.wdata = 10'(10'h0C0 + 3 * i);
            @(negedge clk);
        end
        bus1.we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(1, 10'(10'h300 + i), 10'(10'h0C0 + 3 * i), "b2b_readback");
        end

        // X on we is treated as no write.
        @(negedge clk);
        bus1.we = 1'bx; bus1.address = 10'h020; bus1.wdata = 10'h3AB;
        @(negedge clk);
        bus1.we = 1'b0;
        rd(1, 10'h020, 10'd0, "x_we_no_write");

        // Out-of-range on the DEPTH=1000 instance.
        wr(2, 10'd0,   10'h2C3);
        wr(2, 10'd999, 10'h05A);
        wr(2, 10'd1000, 10'h111);
        rd(2, 10'd1000, 10'd0,   "oor_read_1000");
        rd(2, 10'd0,    10'h2C3, "oor_a0_unchanged");
        rd(2, 10'd999,  10'h05A, "oor_a999_unchanged");
        rd(2, 10'd488,  10'd0,   "oor_no_alias");

        // Reset mid-operation wipes written data.
        wr(1, 10'd7, 10'h0FF);
        rd(1, 10'd7, 10'h0FF, "pre_rst_a7");
        do_reset(1, "rst2");
        rd(1, 10'd7,     10'd0, "post_rst_a7");
        rd(1, 10'h0A4,   10'd0, "post_rst_a0a4");
        rd(2, 10'd0,     10'd0, "post_rst_d2_a0");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_task2.md
Name: ram_task2

Overview:
- Single-port 1024x10 data RAM that backs the L1 cache's memory interface.
- Combinational read path: the cache captures read data in the same cycle it presents the address.
- Synchronous write port.
- After every reset, a hardware sweep clears the whole array to INIT_VALUE before normal accesses are accepted.

Parameters:
- DATA_W, 10, word width of wdata/rdata.
- ADDR_W, 10, address width.
- DEPTH, 1024, number of words; must be ≤ 2^ADDR_W.
- INIT_VALUE, 0, value written to every word during the post-reset sweep.

Ports:
- clk  input  1  rising-edge clock; sole clock domain.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write enable; 1 = write wdata to address at next rising edge, 0 = read only.
- address  input  ADDR_W  word address for both read and write.
- wdata  input  DATA_W  write data.
- rdata  output  DATA_W  read data, combinational from address.
- init_busy  output  1  high while reset is asserted or the clear sweep is running; accesses are ignored while high.

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high; it is sampled only at rising clk edges.
- State machine has two states: INIT and READY.
- Storage: DEPTH x DATA_W array plus an ADDR_W-bit sweep counter.
- Reset:
  - rst=1 at an edge sets state INIT and sweep counter 0.
  - While rst=1, init_busy=1, rdata=0, and no array writes occur.
  - Array contents are undefined until the sweep overwrites them.
- INIT (rst=0):
  - Each rising edge writes INIT_VALUE to array[counter], then counter increments.
  - The edge that writes entry DEPTH-1 moves the state to READY and clears init_busy.
  - init_busy therefore stays high for exactly DEPTH cycles after rst deasserts.
  - In INIT, we/wdata/address are ignored and rdata=0.
- READY, read:
  - rdata = array[address] combinationally, with zero latency, independent of we.
- READY, write:
  - we=1 at a rising edge stores wdata into array[address].
  - rdata shows the new value from that edge onward while address is held.
  - In the same cycle, before the edge, rdata still shows the old contents (read-before-write within a cycle).
- Out-of-range (address ≥ DEPTH, only possible when DEPTH < 2^ADDR_W):
  - Reads return 0.
  - Writes are dropped; no aliasing and no wrap.
- Reset mid-sweep or mid-operation: the next edge with rst=1 restarts the sweep at entry 0; previously written data is lost.
- Back-to-back writes: one write per cycle, no bubbles, any address order.
- we held high with a constant address rewrites the same word every cycle; this is not an error.
- X on we while READY: treat as no write.
- No read-enable and no ready handshake beyond init_busy. The consumer (cache) must not issue requests while init_busy=1.

Test Plan:
- Reset/sweep: rst=1 for 2 cycles, then 0 → init_busy=1 for exactly 1024 cycles after deassertion, then 0; reading addresses 0, 511, 1023 gives 10'd0.
- Write/read: after init, write 10'h155 to addr 10'h0A4 and 10'h2AA to addr 10'h0A5, we=1 one cycle each → with we=0, addr 10'h0A4 reads 10'h155 and 10'h0A5 reads 10'h2AA combinationally in the same cycle as the address change.
- Same-cycle collision: addr 10'h010 holds 10'h001; apply we=1, wdata=10'h3FF → rdata=10'h001 before the edge, 10'h3FF after the edge.
- Writes during sweep: we=1, address 5, wdata 10'h123 during INIT → after init completes, addr 5 reads 10'd0.
- Reset mid-operation: write 10'h0FF to addr 7, assert rst for 1 cycle mid-run → init_busy high 1024 cycles again; addr 7 reads 0 afterwards.
- Out-of-range with DEPTH=1000: write 10'h111 to addr 1000 → addr 1000 reads 0; addrs 0 and 999 are unchanged.
